// File: rtl/mandel_pixel_scheduler_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot pixel scheduler.
package mandel_pkg;
   localparam int WIDTH = 27;
   localparam int FRAC  = 23;
   localparam logic [WIDTH-1:0] FP_ONE  = 27'h0800000;
   localparam logic [WIDTH-1:0] FP_FOUR = 27'h2000000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      EMIT,
      DONE
   } state_t;

   // Integer to signed 4.23; out-of-range values wrap like the accumulators.
   function automatic logic [WIDTH-1:0] to_fp(input integer v);
      logic [WIDTH-1:0] r;
      r = WIDTH'(v) << FRAC;
      return r;
   endfunction
endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// Pixel result handshake towards the colour/VGA writer.
interface mandel_pixel_scheduler_if;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_iter;
   logic        pix_valid;
   logic        pix_ready;

   modport master (output pix_x, pix_y, pix_iter, pix_valid, input pix_ready);
   modport slave  (input pix_x, pix_y, pix_iter, pix_valid, output pix_ready);
endinterface

// File: rtl/mandel_pixel_scheduler_stepper.sv
// Raster position counters and the cr/ci accumulators that follow them.
module mandel_coord_stepper
   import mandel_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             advance_i,
   input  logic [WIDTH-1:0] x_start_i,
   input  logic [WIDTH-1:0] y_start_i,
   input  logic [WIDTH-1:0] dx_i,
   input  logic [WIDTH-1:0] dy_i,
   output logic [9:0]       x_o,
   output logic [8:0]       y_o,
   output logic [WIDTH-1:0] cr_o,
   output logic [WIDTH-1:0] ci_o,
   output logic             last_col_o,
   output logic             last_frame_o
);
   logic [9:0]       x_q, x_d;
   logic [8:0]       y_q, y_d;
   logic [WIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
   logic [WIDTH-1:0] x_start_q, x_start_d, dx_q, dx_d, dy_q, dy_d;

   assign last_col_o   = (x_q == 10'(H_RES - 1));
   assign last_frame_o = last_col_o && (y_q == 9'(V_RES - 1));
   assign x_o  = x_q;
   assign y_o  = y_q;
   assign cr_o = cr_q;
   assign ci_o = ci_q;

   // Next position: load restarts at column 0 of row 0, advance walks in raster order.
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      cr_d      = cr_q;
      ci_d      = ci_q;
      x_start_d = x_start_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      if (load_i) begin
         x_start_d = x_start_i;
         dx_d      = dx_i;
         dy_d      = dy_i;
         x_d       = '0;
         y_d       = '0;
         cr_d      = x_start_i;
         ci_d      = y_start_i;
      end else if (advance_i) begin
         if (last_col_o) begin
            x_d  = '0;
            y_d  = y_q + 9'd1;
            cr_d = x_start_q;
            ci_d = ci_q + dy_q;
         end else begin
            x_d  = x_q + 10'd1;
            cr_d = cr_q + dx_q;
         end
      end
   end

   // Position and accumulator registers; wrap modulo 2^WIDTH by construction.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         cr_q      <= '0;
         ci_q      <= '0;
         x_start_q <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         cr_q      <= cr_d;
         ci_q      <= ci_d;
         x_start_q <= x_start_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
      end
   end
endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Frame sequencer: starts the iterator per pixel, detects completion, hands results on.
//   state | meaning
//   IDLE  | waiting for go, iterator held cleared
//   LOAD  | cr/ci stable, iterator clears z and count this edge
//   RUN   | iterator running, watch for the count to stop moving
//   EMIT  | result presented, waiting for pix_ready
//   DONE  | one-cycle frame_done pulse
module mandel_pixel_scheduler
   import mandel_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      go_i,
   input  logic [WIDTH-1:0]          x_start_i,
   input  logic [WIDTH-1:0]          y_start_i,
   input  logic [WIDTH-1:0]          dx_i,
   input  logic [WIDTH-1:0]          dy_i,
   input  logic [15:0]               max_iterations_i,
   output logic [WIDTH-1:0]          cr_o,
   output logic [WIDTH-1:0]          ci_o,
   output logic [15:0]               iter_max_o,
   output logic                      iter_reset_o,
   input  logic [15:0]               iterations_i,
   mandel_pixel_scheduler_if.master  pix,
   output logic                      busy_o,
   output logic                      frame_done_o
);
   state_t      state_q, state_d;
   logic [15:0] iter_max_q, iter_max_d;
   logic [15:0] pix_iter_q, pix_iter_d;
   logic [15:0] prev_q, prev_d;
   logic        armed_q, armed_d;
   logic        start, handshake, run_done, last_col, last_frame;

   assign start     = (state_q == IDLE) && go_i;
   assign handshake = (state_q == EMIT) && pix.pix_ready;
   // The iterator bumps its count every running cycle, so a repeated value means it stopped.
   assign run_done  = (state_q == RUN) && armed_q && (iterations_i == prev_q);

   mandel_coord_stepper #(.H_RES(H_RES), .V_RES(V_RES)) u_stepper (
      .clk          (clk),
      .reset        (reset),
      .load_i       (start),
      .advance_i    (handshake && !last_frame),
      .x_start_i    (x_start_i),
      .y_start_i    (y_start_i),
      .dx_i         (dx_i),
      .dy_i         (dy_i),
      .x_o          (pix.pix_x),
      .y_o          (pix.pix_y),
      .cr_o         (cr_o),
      .ci_o         (ci_o),
      .last_col_o   (last_col),
      .last_frame_o (last_frame)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go_i) state_d = LOAD;
         LOAD:    state_d = RUN;
         RUN:     if (run_done) state_d = EMIT;
         EMIT:    if (pix.pix_ready) state_d = last_frame ? DONE : LOAD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs; the iterator is held cleared everywhere except RUN.
   always_comb begin
      iter_reset_o  = (state_q != RUN);
      pix.pix_valid = (state_q == EMIT);
      busy_o        = (state_q == LOAD) || (state_q == RUN) || (state_q == EMIT);
      frame_done_o  = (state_q == DONE);
   end

   // Done-detection and result datapath next values.
   always_comb begin
      iter_max_d = start ? max_iterations_i : iter_max_q;
      pix_iter_d = run_done ? iterations_i : pix_iter_q;
      prev_d     = (state_q == RUN) ? iterations_i : prev_q;
      armed_d    = (state_q == RUN);
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         iter_max_q <= '0;
         pix_iter_q <= '0;
         prev_q     <= '0;
         armed_q    <= 1'b0;
      end else begin
         iter_max_q <= iter_max_d;
         pix_iter_q <= pix_iter_d;
         prev_q     <= prev_d;
         armed_q    <= armed_d;
      end
   end

   assign iter_max_o   = iter_max_q;
   assign pix.pix_iter = pix_iter_q;
endmodule
